// File: rtl/jpeg_axis_pkg.sv
// Shared definitions for the JPEG block adapter: FSM encoding, output lane width
// and the coefficient sign-extension helper.
package jpeg_axis_pkg;

   localparam int LANE_W = 16;

   typedef enum logic [1:0] {
      ST_RECV      = 2'd0,
      ST_START     = 2'd1,
      ST_WAIT_CORE = 2'd2,
      ST_SEND      = 2'd3
   } state_t;

   // Bits at and above position w are copies of bit w-1.
   function automatic logic [LANE_W-1:0] sext_lane(input logic [LANE_W-1:0] v, input int w);
      logic [LANE_W-1:0] r;
      for (int i = 0; i < LANE_W; i++) begin
         r[i] = (i < w) ? v[i] : v[w-1];
      end
      return r;
   endfunction

endpackage

// File: rtl/jpeg_axis_block_adapter_if.sv
// AXI-Stream style bundle used for the coefficient output path.
// A beat transfers on a rising clock edge where tvalid and tready are both high; once tvalid
// is raised, tvalid/tdata/tlast/tstrb hold until that transfer, and tready may toggle freely.
interface jpeg_axis_block_adapter_if #(
   parameter int DATA_W = 32
);
   logic              tvalid;
   logic              tready;
   logic              tlast;
   logic [DATA_W-1:0] tdata;
   logic [DATA_W/8-1:0] tstrb;

   modport master (output tvalid, output tlast, output tdata, output tstrb, input tready);
   modport slave  (input tvalid, input tlast, input tdata, input tstrb, output tready);
endinterface

// File: rtl/jpeg_axis_coef_serializer.sv
// Holds one block of core coefficients and streams it out channel by channel,
// CPB sign-extended 16-bit lanes per beat, through a registered output stage.
module jpeg_axis_coef_serializer
   import jpeg_axis_pkg::*;
#(
   parameter int NUM_CH      = 3,
   parameter int COEF_W      = 15,
   parameter int BLK         = 64,
   parameter int M_W         = 32,
   parameter int LAST_PER_CH = 1
) (
   input  logic                          i_clk,
   input  logic                          i_rst_n,
   input  logic                          i_load,
   input  logic [NUM_CH*BLK*COEF_W-1:0]  i_coef,
   output logic                          o_done,
   jpeg_axis_block_adapter_if.master     m_axis
);

   localparam int CPB    = M_W / LANE_W;
   localparam int BPC    = BLK / CPB;
   localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int BEAT_W = (BPC > 1) ? $clog2(BPC) : 1;
   localparam int TOT_W  = NUM_CH * BLK * COEF_W;

   logic [TOT_W-1:0]   r_buf;
   logic [CH_W-1:0]    r_ch;
   logic [BEAT_W-1:0]  r_beat;
   logic               r_tvalid;
   logic               r_tlast;
   logic [M_W-1:0]     r_tdata;
   logic [M_W/8-1:0]   r_tstrb;

   logic               w_last_beat;
   logic               w_last_ch;
   logic               w_fire;
   logic [CH_W-1:0]    w_nch;
   logic [BEAT_W-1:0]  w_nbeat;

   function automatic logic [M_W-1:0] pick_beat(input logic [TOT_W-1:0] src, input int ch,
                                                input int beat);
      logic [M_W-1:0] v;
      v = '0;
      for (int k = 0; k < CPB; k++) begin
         v[k*LANE_W +: LANE_W] =
            sext_lane(LANE_W'(src[(ch*BLK + beat*CPB + k)*COEF_W +: COEF_W]), COEF_W);
      end
      return v;
   endfunction

   function automatic logic last_of(input int beat, input int ch);
      return (beat == BPC-1) && ((LAST_PER_CH != 0) || (ch == NUM_CH-1));
   endfunction

   assign w_last_beat = (r_beat == BEAT_W'(BPC-1));
   assign w_last_ch   = (r_ch == CH_W'(NUM_CH-1));
   assign w_fire      = r_tvalid && m_axis.tready;
   assign o_done      = w_fire && w_last_beat && w_last_ch;

   always_comb begin
      w_nbeat = r_beat + 1'b1;
      w_nch   = r_ch;
      if (w_last_beat) begin
         w_nbeat = '0;
         w_nch   = r_ch + 1'b1;
      end
   end

   // The first beat is built straight from i_coef so tvalid rises the cycle after the load.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_buf    <= '0;
         r_ch     <= '0;
         r_beat   <= '0;
         r_tvalid <= 1'b0;
         r_tlast  <= 1'b0;
         r_tdata  <= '0;
         r_tstrb  <= '0;
      end else if (i_load) begin
         r_buf    <= i_coef;
         r_ch     <= '0;
         r_beat   <= '0;
         r_tvalid <= 1'b1;
         r_tstrb  <= '1;
         r_tdata  <= pick_beat(i_coef, 0, 0);
         r_tlast  <= last_of(0, 0);
      end else if (w_fire) begin
         if (o_done) begin
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
            r_tstrb  <= '0;
            r_tdata  <= '0;
         end else begin
            r_ch    <= w_nch;
            r_beat  <= w_nbeat;
            r_tdata <= pick_beat(r_buf, int'(w_nch), int'(w_nbeat));
            r_tlast <= last_of(int'(w_nbeat), int'(w_nch));
         end
      end
   end

   assign m_axis.tvalid = r_tvalid;
   assign m_axis.tlast  = r_tlast;
   assign m_axis.tdata  = r_tdata;
   assign m_axis.tstrb  = r_tstrb;

endmodule

// File: rtl/jpeg_axis_block_adapter.sv
// Collects a planar pixel block from an input stream, hands it to a compute core,
// and streams the core's coefficients back out.
module jpeg_axis_block_adapter
   import jpeg_axis_pkg::*;
#(
   parameter int NUM_CH      = 3,
   parameter int PIX_W       = 8,
   parameter int COEF_W      = 15,
   parameter int BLK         = 64,
   parameter int S_W         = 32,
   parameter int M_W         = 32,
   parameter int LAST_PER_CH = 1
) (
   input  logic                          s00_axis_aclk,
   input  logic                          s00_axis_aresetn,
   input  logic                          s00_axis_tvalid,
   output logic                          s00_axis_tready,
   input  logic                          s00_axis_tlast,
   input  logic [S_W-1:0]                s00_axis_tdata,
   output logic                          m00_axis_tvalid,
   input  logic                          m00_axis_tready,
   output logic                          m00_axis_tlast,
   output logic [M_W-1:0]                m00_axis_tdata,
   output logic [M_W/8-1:0]              m00_axis_tstrb,
   output logic                          core_start,
   output logic [NUM_CH*BLK*PIX_W-1:0]   core_pix,
   input  logic                          core_done,
   input  logic [NUM_CH*BLK*COEF_W-1:0]  core_coef,
   output logic                          err_early_last,
   output logic                          err_missing_last,
   output logic                          busy
);

   localparam int PPB    = S_W / PIX_W;
   localparam int BPB    = BLK / PPB;
   localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int BEAT_W = (BPB > 1) ? $clog2(BPB) : 1;

   state_t                       r_state;
   logic [CH_W-1:0]              r_ch;
   logic [BEAT_W-1:0]            r_beat;
   logic [NUM_CH*BLK*PIX_W-1:0]  r_pix;
   logic                         r_core_start;
   logic                         r_err_early;
   logic                         r_err_missing;

   logic                         w_accept;
   logic                         w_final_beat;
   logic                         w_early;
   logic                         w_load;
   logic                         w_ser_done;

   jpeg_axis_block_adapter_if #(.DATA_W(M_W)) w_m_if ();

   assign w_accept     = (r_state == ST_RECV) && s00_axis_tvalid;
   assign w_final_beat = (r_beat == BEAT_W'(BPB-1));
   assign w_early      = s00_axis_tlast && !w_final_beat;
   assign w_load       = (r_state == ST_WAIT_CORE) && core_done;

   always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
      if (!s00_axis_aresetn) begin
         r_state       <= ST_RECV;
         r_ch          <= '0;
         r_beat        <= '0;
         r_core_start  <= 1'b0;
         r_err_early   <= 1'b0;
         r_err_missing <= 1'b0;
      end else begin
         case (r_state)
            ST_RECV: begin
               if (w_accept) begin
                  if (w_early)
                     r_err_early <= 1'b1;
                  if (w_final_beat && !s00_axis_tlast)
                     r_err_missing <= 1'b1;
                  if (w_final_beat || s00_axis_tlast) begin
                     r_beat <= '0;
                     if (r_ch == CH_W'(NUM_CH-1)) begin
                        r_ch         <= '0;
                        r_state      <= ST_START;
                        r_core_start <= 1'b1;
                     end else begin
                        r_ch <= r_ch + 1'b1;
                     end
                  end else begin
                     r_beat <= r_beat + 1'b1;
                  end
               end
            end
            ST_START: begin
               r_core_start <= 1'b0;
               r_state      <= ST_WAIT_CORE;
            end
            ST_WAIT_CORE: begin
               if (core_done)
                  r_state <= ST_SEND;
            end
            ST_SEND: begin
               if (w_ser_done)
                  r_state <= ST_RECV;
            end
            default: r_state <= ST_RECV;
         endcase
      end
   end

   // An early tlast zero-fills the rest of the current channel so stale pixels never reach the core.
   always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
      if (!s00_axis_aresetn) begin
         r_pix <= '0;
      end else if (w_accept) begin
         for (int c = 0; c < NUM_CH; c++) begin
            for (int i = 0; i < BLK; i++) begin
               if (c == int'(r_ch)) begin
                  if (i / PPB == int'(r_beat))
                     r_pix[(c*BLK + i)*PIX_W +: PIX_W] <= s00_axis_tdata[(i % PPB)*PIX_W +: PIX_W];
                  else if (w_early && (i / PPB > int'(r_beat)))
                     r_pix[(c*BLK + i)*PIX_W +: PIX_W] <= '0;
               end
            end
         end
      end
   end

   jpeg_axis_coef_serializer #(
      .NUM_CH      (NUM_CH),
      .COEF_W      (COEF_W),
      .BLK         (BLK),
      .M_W         (M_W),
      .LAST_PER_CH (LAST_PER_CH)
   ) u_ser (
      .i_clk   (s00_axis_aclk),
      .i_rst_n (s00_axis_aresetn),
      .i_load  (w_load),
      .i_coef  (core_coef),
      .o_done  (w_ser_done),
      .m_axis  (w_m_if)
   );

   assign w_m_if.tready    = m00_axis_tready;
   assign m00_axis_tvalid  = w_m_if.tvalid;
   assign m00_axis_tlast   = w_m_if.tlast;
   assign m00_axis_tdata   = w_m_if.tdata;
   assign m00_axis_tstrb   = w_m_if.tstrb;

   assign s00_axis_tready  = (r_state == ST_RECV);
   assign core_start       = r_core_start;
   assign core_pix         = r_pix;
   assign err_early_last   = r_err_early;
   assign err_missing_last = r_err_missing;
   assign busy             = !((r_state == ST_RECV) && (r_ch == '0) && (r_beat == '0));

endmodule
